// File: rtl/reaction_ctrl_pkg.sv
// Shared types and constants for the reaction timer.
// State encoding, LED-block phase codes and the default counter width.
package reaction_ctrl_pkg;

    localparam int MS_W_DEF = 14;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_TIME,
        S_DONE,
        S_FOUL
    } state_e;

    localparam logic [2:0] FLAG_IDLE  = 3'd0;
    localparam logic [2:0] FLAG_ARMED = 3'd1;
    localparam logic [2:0] FLAG_DONE  = 3'd2;
    localparam logic [2:0] FLAG_FOUL  = 3'd3;

    function automatic logic [2:0] flag_of(input state_e s);
        logic [2:0] f;
        f = FLAG_IDLE;
        case (s)
            S_WAIT:  f = FLAG_ARMED;
            S_TIME:  f = FLAG_ARMED;
            S_DONE:  f = FLAG_DONE;
            S_FOUL:  f = FLAG_FOUL;
            default: f = FLAG_IDLE;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/reaction_ctrl_rise.sv
// Rising-edge detector for a debounced, clk-synchronous button level.
// A level already high when reset is released is swallowed until re-pressed.
module rise_det (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic rise_o
);

    logic hist_q;
    logic primed_q;

    // Track previous level; primed_q masks the first cycle out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q   <= 1'b0;
            primed_q <= 1'b0;
        end else begin
            hist_q   <= d_i;
            primed_q <= 1'b1;
        end
    end

    assign rise_o = d_i & ~hist_q & primed_q;

endmodule

// File: rtl/reaction_ctrl.sv
// Reaction-time game controller: arm, time the response, flag fouls
// and keep the last and best valid reaction times.
module reaction_ctrl
    import reaction_ctrl_pkg::*;
#(
    parameter int TIMEOUT_MS = 9999,
    parameter int MS_W       = MS_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tick_1ms,
    input  logic            btn_start,
    input  logic            btn_stop,
    input  logic            go_led,
    output logic [2:0]      flag,
    output logic [MS_W-1:0] react_ms,
    output logic [MS_W-1:0] best_ms,
    output logic            result_valid,
    output logic            timeout
);

    localparam logic [MS_W-1:0] TMO     = MS_W'(TIMEOUT_MS);
    localparam logic [MS_W-1:0] CNT_MAX = '1;

    logic start_ev;
    logic stop_ev;

    state_e          state_q, state_d;
    logic [2:0]      flag_q, flag_d;
    logic [MS_W-1:0] cnt_q, cnt_d;
    logic [MS_W-1:0] react_q, react_d;
    logic [MS_W-1:0] best_q, best_d;
    logic            valid_q, valid_d;
    logic            tmo_q, tmo_d;

    rise_det u_start (
        .clk    (clk),
        .rst    (rst),
        .d_i    (btn_start),
        .rise_o (start_ev)
    );

    rise_det u_stop (
        .clk    (clk),
        .rst    (rst),
        .d_i    (btn_stop),
        .rise_o (stop_ev)
    );

    // Next-state, counter and result logic; stop always wins its cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        react_d = react_q;
        best_d  = best_q;
        valid_d = 1'b0;
        tmo_d   = tmo_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_ev) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (stop_ev) begin
                    state_d = S_FOUL;
                    tmo_d   = 1'b0;
                end else if (go_led) begin
                    state_d = S_TIME;
                    cnt_d   = '0;
                end
            end
            S_TIME: begin
                if (stop_ev) begin
                    state_d = S_DONE;
                    react_d = cnt_q;
                    valid_d = 1'b1;
                    if (cnt_q < best_q) best_d = cnt_q;
                end else if (cnt_q == TMO) begin
                    state_d = S_FOUL;
                    tmo_d   = 1'b1;
                end else if (tick_1ms && cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE, S_FOUL: begin
                if (start_ev) begin
                    state_d = S_IDLE;
                    tmo_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        flag_d = flag_of(state_d);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            flag_q  <= FLAG_IDLE;
            cnt_q   <= '0;
            react_q <= '0;
            best_q  <= '1;
            valid_q <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            flag_q  <= flag_d;
            cnt_q   <= cnt_d;
            react_q <= react_d;
            best_q  <= best_d;
            valid_q <= valid_d;
            tmo_q   <= tmo_d;
        end
    end

    assign flag         = flag_q;
    assign react_ms     = react_q;
    assign best_ms      = best_q;
    assign result_valid = valid_q;
    assign timeout      = tmo_q;

endmodule

// File: tb/tb_reaction_ctrl.sv
// Directed bench for reaction_ctrl: cycle table plus multi-cycle scenarios.
// Instance a uses the default timeout, instance b a 20 ms timeout.
module tb_reaction_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick_1ms = 1'b0;
    logic        btn_start = 1'b0;
    logic        btn_stop = 1'b0;
    logic        go_led = 1'b0;

    logic [2:0]  flag_a, flag_b;
    logic [13:0] react_a, react_b;
    logic [13:0] best_a, best_b;
    logic        valid_a, valid_b;
    logic        tmo_a, tmo_b;

    int nchk = 0;
    int nfail = 0;
    int vcnt = 0;
    int v0;

    localparam logic [13:0] ONES = 14'h3FFF;

    reaction_ctrl u_a (
        .clk          (clk),
        .rst          (rst),
        .tick_1ms     (tick_1ms),
        .btn_start    (btn_start),
        .btn_stop     (btn_stop),
        .go_led       (go_led),
        .flag         (flag_a),
        .react_ms     (react_a),
        .best_ms      (best_a),
        .result_valid (valid_a),
        .timeout      (tmo_a)
    );

    reaction_ctrl #(.TIMEOUT_MS(20)) u_b (
        .clk          (clk),
        .rst          (rst),
        .tick_1ms     (tick_1ms),
        .btn_start    (btn_start),
        .btn_stop     (btn_stop),
        .go_led       (go_led),
        .flag         (flag_b),
        .react_ms     (react_b),
        .best_ms      (best_b),
        .result_valid (valid_b),
        .timeout      (tmo_b)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (valid_a) vcnt++;

    typedef struct {
        logic        st, sp, go, tk;
        logic [2:0]  f;
        logic [13:0] r;
        logic        v;
        logic        t;
        logic [13:0] b;
    } vec_t;

    vec_t tbl[23];

    function automatic vec_t mk(input logic [3:0] in, input logic [2:0] f,
                                input logic [13:0] r, input logic v,
                                input logic t, input logic [13:0] b);
        vec_t x;
        x.st = in[3]; x.sp = in[2]; x.go = in[1]; x.tk = in[0];
        x.f = f; x.r = r; x.v = v; x.t = t; x.b = b;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(input logic st, input logic sp,
                        input logic go, input logic tk);
        btn_start = st;
        btn_stop  = sp;
        go_led    = go;
        tick_1ms  = tk;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        step(0, 0, 0, 0);
        rst = 1'b1;
        repeat (2) step(0, 0, 0, 0);
        rst = 1'b0;
        repeat (2) step(0, 0, 0, 0);
    endtask

    task automatic do_run(input int n, input logic tk_at_stop);
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        for (int i = 0; i < n; i++) step(0, 0, 1, 1);
        step(0, 1, 1, tk_at_stop);
    endtask

    task automatic to_idle();
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
    endtask

    initial begin
        tbl[0]  = mk(4'b0000, 0, 0, 0, 0, ONES);
        tbl[1]  = mk(4'b1000, 1, 0, 0, 0, ONES);
        tbl[2]  = mk(4'b1000, 1, 0, 0, 0, ONES);
        tbl[3]  = mk(4'b0001, 1, 0, 0, 0, ONES);
        tbl[4]  = mk(4'b0010, 1, 0, 0, 0, ONES);
        tbl[5]  = mk(4'b0011, 1, 0, 0, 0, ONES);
        tbl[6]  = mk(4'b0011, 1, 0, 0, 0, ONES);
        tbl[7]  = mk(4'b0010, 1, 0, 0, 0, ONES);
        tbl[8]  = mk(4'b0111, 2, 2, 1, 0, 2);
        tbl[9]  = mk(4'b0110, 2, 2, 0, 0, 2);
        tbl[10] = mk(4'b0000, 2, 2, 0, 0, 2);
        tbl[11] = mk(4'b1000, 0, 2, 0, 0, 2);
        tbl[12] = mk(4'b0100, 0, 2, 0, 0, 2);
        tbl[13] = mk(4'b1000, 1, 2, 0, 0, 2);
        tbl[14] = mk(4'b0110, 3, 2, 0, 0, 2);
        tbl[15] = mk(4'b0000, 3, 2, 0, 0, 2);
        tbl[16] = mk(4'b1000, 0, 2, 0, 0, 2);
        tbl[17] = mk(4'b0000, 0, 2, 0, 0, 2);
        tbl[18] = mk(4'b1000, 1, 2, 0, 0, 2);
        tbl[19] = mk(4'b0010, 1, 2, 0, 0, 2);
        tbl[20] = mk(4'b0000, 1, 2, 0, 0, 2);
        tbl[21] = mk(4'b1001, 1, 2, 0, 0, 2);
        tbl[22] = mk(4'b0100, 2, 1, 1, 0, 1);

        // Reset values while rst is held.
        #12;
        chk("rst_flag", flag_a, 0);
        chk("rst_react", react_a, 0);
        chk("rst_best", best_a, ONES);
        chk("rst_valid", valid_a, 0);
        chk("rst_tmo", tmo_a, 0);
        reset_dut();

        // Cycle-by-cycle table.
        for (int i = 0; i < 23; i++) begin
            step(tbl[i].st, tbl[i].sp, tbl[i].go, tbl[i].tk);
            chk($sformatf("tbl%0d_flag", i), flag_a, tbl[i].f);
            chk($sformatf("tbl%0d_react", i), react_a, tbl[i].r);
            chk($sformatf("tbl%0d_valid", i), valid_a, tbl[i].v);
            chk($sformatf("tbl%0d_tmo", i), tmo_a, tbl[i].t);
            chk($sformatf("tbl%0d_best", i), best_a, tbl[i].b);
        end

        // Normal 237 ms run.
        reset_dut();
        v0 = vcnt;
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        for (int i = 0; i < 237; i++) step(0, 0, 1, 1);
        chk("run237_flag_pre", flag_a, 1);
        step(0, 1, 1, 0);
        chk("run237_flag", flag_a, 2);
        chk("run237_react", react_a, 237);
        chk("run237_valid", valid_a, 1);
        step(0, 0, 0, 0);
        chk("run237_pulse_cnt", vcnt - v0, 1);
        chk("run237_best", best_a, 237);

        // Early press: stop while go_led low.
        to_idle();
        v0 = vcnt;
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        chk("early_flag", flag_a, 3);
        chk("early_tmo", tmo_a, 0);
        chk("early_react", react_a, 237);
        step(0, 0, 0, 0);
        chk("early_novalid", vcnt - v0, 0);

        // Best tracking over 300, 180, 250.
        reset_dut();
        do_run(300, 0);
        to_idle();
        do_run(180, 0);
        to_idle();
        do_run(250, 0);
        chk("best_best", best_a, 180);
        chk("best_react", react_a, 250);
        to_idle();

        // Stop and tick together at count 50.
        do_run(50, 1);
        chk("stoptick_react", react_a, 50);
        chk("stoptick_best", best_a, 50);
        to_idle();

        // Reset mid-TIME at count 100 with start held.
        v0 = vcnt;
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        for (int i = 0; i < 100; i++) step(0, 0, 1, 1);
        step(1, 0, 1, 0);
        chk("midrst_flag_pre", flag_a, 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_flag", flag_a, 0);
        chk("midrst_react", react_a, 0);
        chk("midrst_best", best_a, ONES);
        chk("midrst_valid", valid_a, 0);
        chk("midrst_tmo", tmo_a, 0);
        @(posedge clk);
        #1;
        step(1, 0, 0, 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0);
            chk($sformatf("held_start%0d", i), flag_a, 0);
        end
        chk("midrst_novalid", vcnt - v0, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("repress_flag", flag_a, 1);

        // Timeout on the 20 ms instance.
        reset_dut();
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 1, 1);
        chk("tmo_flag_pre", flag_b, 1);
        step(0, 0, 1, 0);
        chk("tmo_flag", flag_b, 3);
        chk("tmo_tmo", tmo_b, 1);
        chk("tmo_novalid", valid_b, 0);
        step(1, 0, 0, 0);
        chk("tmo_clr_flag", flag_b, 0);
        chk("tmo_clr_tmo", tmo_b, 0);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
